// File: rtl/text_pkg.sv
// Shared constants, glyph codes and FSM states for the
// text console write path.
package text_pkg;

  localparam int COLS = 80;
  localparam int ROWS = 30;

  localparam logic [3:0] GLYPH_BLANK   = 4'h0;
  localparam logic [3:0] GLYPH_DIGIT0  = 4'h1;
  localparam logic [3:0] GLYPH_PLUS    = 4'hB;
  localparam logic [3:0] GLYPH_MINUS   = 4'hC;
  localparam logic [3:0] GLYPH_TIMES   = 4'hD;
  localparam logic [3:0] GLYPH_UNKNOWN = 4'hE;

  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_FF    = 8'h0C;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_PLUS  = 8'h2B;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_9     = 8'h39;
  localparam logic [7:0] ASCII_X     = 8'h78;
  localparam logic [7:0] ASCII_TILDE = 8'h7E;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLR_ROW = 2'd1,
    CLR_ALL = 2'd2
  } tw_state_t;

endpackage

// File: rtl/text_glyph_encode.sv
// ASCII byte to 4-bit display glyph, plus a printable flag.
// Purely combinational so any producer can share it.
module text_glyph_encode
  import text_pkg::*;
(
  input  logic [7:0] ascii_i,
  output logic [3:0] glyph_o,
  output logic       is_printable_o
);

  always_comb begin
    glyph_o        = GLYPH_UNKNOWN;
    is_printable_o = (ascii_i >= ASCII_SPACE) &&
                     (ascii_i <= ASCII_TILDE);
    unique case (1'b1)
      (ascii_i == ASCII_SPACE): glyph_o = GLYPH_BLANK;
      (ascii_i >= ASCII_0 && ascii_i <= ASCII_9):
        glyph_o = GLYPH_DIGIT0 + 4'(ascii_i - ASCII_0);
      (ascii_i == ASCII_PLUS):  glyph_o = GLYPH_PLUS;
      (ascii_i == ASCII_MINUS): glyph_o = GLYPH_MINUS;
      (ascii_i == ASCII_X):     glyph_o = GLYPH_TIMES;
      default:                  glyph_o = GLYPH_UNKNOWN;
    endcase
  end

endmodule

// File: rtl/text_console_writer.sv
// Cursor-tracking writer feeding the text_buffer port, with
// multi-cycle row and screen clears.
module text_console_writer #(
  parameter int COLS = text_pkg::COLS,
  parameter int ROWS = text_pkg::ROWS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_char,
  output logic        in_ready,
  output logic        we,
  output logic [11:0] waddr,
  output logic [3:0]  new_char,
  output logic [4:0]  cursor_row,
  output logic [6:0]  cursor_col
);
  import text_pkg::*;

  localparam logic [6:0] COL_LAST = 7'(COLS - 1);
  localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);

  tw_state_t   state_q, state_d;
  logic [4:0]  row_q, row_d;
  logic [6:0]  col_q, col_d;
  logic [4:0]  crow_q, crow_d;
  logic [6:0]  ccol_q, ccol_d;
  logic        done_q, done_d;
  logic        we_q, we_d;
  logic [11:0] waddr_q, waddr_d;
  logic [3:0]  char_q, char_d;
  logic [3:0]  glyph;
  logic        printable;
  logic        accept;
  logic        col_last;
  logic [4:0]  row_adv;

  text_glyph_encode u_enc (
    .ascii_i        (in_char),
    .glyph_o        (glyph),
    .is_printable_o (printable)
  );

  assign in_ready = (state_q == IDLE);
  assign accept   = in_valid && in_ready;
  assign col_last = (col_q == COL_LAST);
  assign row_adv  = (row_q == ROW_LAST) ? '0
                  : row_q + 5'd1;

  always_ff @(posedge clk) begin
    if (rst) state_q <= CLR_ALL;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_char == ASCII_LF ||
              (printable && col_last))
            state_d = CLR_ROW;
          else if (in_char == ASCII_FF)
            state_d = CLR_ALL;
        end
      end
      CLR_ROW, CLR_ALL: begin
        if (done_q) state_d = IDLE;
      end
      default: state_d = CLR_ALL;
    endcase
  end

  always_comb begin
    row_d   = row_q;
    col_d   = col_q;
    crow_d  = crow_q;
    ccol_d  = ccol_q;
    done_d  = done_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    char_d  = char_q;
    case (state_q)
      IDLE: begin
        // Arm the clear counters for whichever clear follows.
        crow_d = '0;
        ccol_d = '0;
        done_d = 1'b0;
        if (accept) begin
          unique case (1'b1)
            printable: begin
              we_d    = 1'b1;
              waddr_d = {row_q, col_q};
              char_d  = glyph;
              if (col_last) begin
                col_d = '0;
                row_d = row_adv;
              end else begin
                col_d = col_q + 7'd1;
              end
            end
            (in_char == ASCII_LF): begin
              col_d = '0;
              row_d = row_adv;
            end
            (in_char == ASCII_CR): col_d = '0;
            (in_char == ASCII_BS): begin
              if (col_q != '0) begin
                col_d   = col_q - 7'd1;
                we_d    = 1'b1;
                waddr_d = {row_q, col_q - 7'd1};
                char_d  = GLYPH_BLANK;
              end
            end
            (in_char == ASCII_FF): begin
              row_d = '0;
              col_d = '0;
            end
            default: ;
          endcase
        end
      end
      CLR_ROW: begin
        if (!done_q) begin
          we_d    = 1'b1;
          waddr_d = {row_q, ccol_q};
          char_d  = GLYPH_BLANK;
          if (ccol_q == COL_LAST) done_d = 1'b1;
          else ccol_d = ccol_q + 7'd1;
        end
      end
      CLR_ALL: begin
        if (!done_q) begin
          we_d    = 1'b1;
          waddr_d = {crow_q, ccol_q};
          char_d  = GLYPH_BLANK;
          if (ccol_q == COL_LAST) begin
            ccol_d = '0;
            if (crow_q == ROW_LAST) done_d = 1'b1;
            else crow_d = crow_q + 5'd1;
          end else begin
            ccol_d = ccol_q + 7'd1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q   <= '0;
      col_q   <= '0;
      crow_q  <= '0;
      ccol_q  <= '0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      char_q  <= '0;
    end else begin
      row_q   <= row_d;
      col_q   <= col_d;
      crow_q  <= crow_d;
      ccol_q  <= ccol_d;
      done_q  <= done_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      char_q  <= char_d;
    end
  end

  assign we         = we_q;
  assign waddr      = waddr_q;
  assign new_char   = char_q;
  assign cursor_row = row_q;
  assign cursor_col = col_q;

endmodule

// File: tb/tb_text_console_writer.sv
// Directed and random bench for text_console_writer against a
// cursor/screen reference model with cycle-stamped writes.
module tb_text_console_writer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_char;
  logic        in_ready;
  logic        we;
  logic [11:0] waddr;
  logic [3:0]  new_char;
  logic [4:0]  cursor_row;
  logic [6:0]  cursor_col;

  text_console_writer dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_char    (in_char),
    .in_ready   (in_ready),
    .we         (we),
    .waddr      (waddr),
    .new_char   (new_char),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col)
  );

  typedef struct {
    int          cyc;
    logic [11:0] addr;
    logic [3:0]  ch;
  } wr_t;

  wr_t wq[$];
  wr_t eq[$];
  int  cyc = 0;
  int  tests = 0;
  int  fails = 0;
  int  mrow = 0;
  int  mcol = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (we === 1'b1) wq.push_back('{cyc, waddr, new_char});

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] pk(input wr_t w);
    return {32'(w.cyc), w.addr, w.ch};
  endfunction

  function automatic logic [11:0] adr(input int r,
                                      input int c);
    return 12'(r * 128 + c);
  endfunction

  function automatic logic [3:0] ref_glyph(input int c);
    if (c == 32) return 4'h0;
    if (c >= 48 && c <= 57) return 4'(c - 48 + 1);
    if (c == 43) return 4'hB;
    if (c == 45) return 4'hC;
    if (c == 120) return 4'hD;
    return 4'hE;
  endfunction

  task automatic push_clear_all(input int start);
    for (int k = 0; k < 2400; k++)
      eq.push_back('{start + k, adr(k / 80, k % 80), 4'h0});
  endtask

  task automatic new_line(input int t0, output int busy);
    mcol = 0;
    mrow = (mrow + 1) % 30;
    for (int k = 0; k < 80; k++)
      eq.push_back('{t0 + 1 + k, adr(mrow, k), 4'h0});
    busy = 81;
  endtask

  // t0 is the cycle right after the accepting edge.
  task automatic model_byte(input int c, input int t0,
                            output int busy);
    busy = 0;
    if (c >= 32 && c <= 126) begin
      eq.push_back('{t0, adr(mrow, mcol), ref_glyph(c)});
      mcol++;
      if (mcol == 80) new_line(t0, busy);
    end else if (c == 10) begin
      new_line(t0, busy);
    end else if (c == 13) begin
      mcol = 0;
    end else if (c == 8) begin
      if (mcol > 0) begin
        mcol--;
        eq.push_back('{t0, adr(mrow, mcol), 4'h0});
      end
    end else if (c == 12) begin
      mrow = 0;
      mcol = 0;
      push_clear_all(t0 + 1);
      busy = 2401;
    end
  endtask

  task automatic wait_ready(input string tag,
                            input int exp_busy);
    int  busy;
    int  n;
    logic ok;
    busy = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) break;
      busy++;
    end
    #1;
    chk({tag, ".busy"}, 64'(busy), 64'(exp_busy));
    chk({tag, ".nwr"}, 64'(wq.size()), 64'(eq.size()));
    n = (wq.size() < eq.size()) ? wq.size() : eq.size();
    for (int i = 0; i < n; i++) begin
      ok = (pk(wq[i]) === pk(eq[i]));
      chk({tag, ".wr"}, 64'(pk(wq[i])), 64'(pk(eq[i])));
      if (!ok) break;
    end
    chk({tag, ".row"}, 64'(cursor_row), 64'(mrow));
    chk({tag, ".col"}, 64'(cursor_col), 64'(mcol));
    wq.delete();
    eq.delete();
  endtask

  task automatic send_byte(input string tag, input int c);
    int busy;
    int t0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_char  = 8'(c);
    for (int i = 0; i < 3000 && in_ready !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    chk({tag, ".rdy"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    t0       = cyc;
    in_valid = 1'b0;
    model_byte(c, t0, busy);
    wait_ready(tag, busy);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, ".we"}, 64'(we), 64'd0);
    chk({tag, ".waddr"}, 64'(waddr), 64'd0);
    chk({tag, ".char"}, 64'(new_char), 64'd0);
    chk({tag, ".ready"}, 64'(in_ready), 64'd0);
  endtask

  task automatic release_reset(input string tag);
    int t0;
    wq.delete();
    eq.delete();
    mrow = 0;
    mcol = 0;
    rst  = 1'b0;
    @(posedge clk); #1;
    t0 = cyc;
    push_clear_all(t0);
    wait_ready(tag, 2400);
  endtask

  initial begin : main
    int   t0;
    int   busy;
    int   c;
    int   r;
    string s;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_char  = 8'h00;

    // Reset and power-on clear.
    @(posedge clk); #1;
    chk_reset_outs("rst");
    @(posedge clk);
    @(posedge clk); #1;
    release_reset("init");

    // Back-to-back "12+" with in_valid held.
    s = "12+";
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_char  = s[0];
    @(posedge clk); #1;
    t0 = cyc;
    model_byte(int'(s[0]), t0, busy);
    in_char = s[1];
    @(posedge clk); #1;
    model_byte(int'(s[1]), t0 + 1, busy);
    in_char = s[2];
    @(posedge clk); #1;
    model_byte(int'(s[2]), t0 + 2, busy);
    in_valid = 1'b0;
    wait_ready("stream", 0);

    // Fill row 5, wrap into row 6.
    for (int i = 0; i < 5; i++) send_byte("lf", 10);
    for (int i = 0; i < 80; i++) send_byte("xrow", 120);

    // Row 29 LF wraps to a cleared row 0.
    for (int i = 0; i < 23; i++) send_byte("lf29", 10);
    for (int i = 0; i < 10; i++) send_byte("dash", 45);
    send_byte("wrap", 10);

    // Backspace at col 0 and mid-row.
    for (int i = 0; i < 3; i++) send_byte("lf3", 10);
    send_byte("bs0", 8);
    s = "a7 q";
    for (int i = 0; i < 4; i++) send_byte("abcd", int'(s[i]));
    send_byte("bs4", 8);
    send_byte("cr", 13);
    send_byte("ign", 8'h1B);

    // Random mix against the model.
    for (int i = 0; i < 200; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 55)      c = int'($urandom_range(32, 126));
      else if (r < 65) c = int'($urandom_range(48, 57));
      else if (r < 75) c = 10;
      else if (r < 80) c = 13;
      else if (r < 88) c = 8;
      else if (r < 90) c = 12;
      else             c = int'($urandom_range(0, 255));
      send_byte("rand", c);
    end

    // Form feed aborted by reset at clear write 1000.
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_char  = 8'h0C;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_char  = 8'h00;
    wq.delete();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      if (wq.size() >= 1000) break;
    end
    chk("ff.reach1000", 64'(wq.size()), 64'd1000);
    in_valid = 1'b1;
    in_char  = 8'h37;
    rst      = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    chk_reset_outs("rst2");
    release_reset("reclr");
    @(posedge clk); #1;
    t0       = cyc;
    in_valid = 1'b0;
    model_byte(8'h37, t0, busy);
    wait_ready("held", busy);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
